// File: rtl/l1_tlb_attr_array.sv
// L1 TLB attribute store: per-entry permission/state bits, refill victim selection
// (first invalid entry, else tree pseudo-LRU), flush, single invalidate and dirty marking.
module l1_tlb_attr_array #(
    parameter int unsigned ENTRIES = 8,
    parameter int unsigned IDX_W   = 3
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_refill_valid,
    input  logic               i_pte_v,
    input  logic               i_pte_u,
    input  logic               i_pte_w,
    input  logic               i_pte_x,
    input  logic               i_pte_r,
    input  logic               i_pte_d,
    input  logic               i_prot_w,
    input  logic               i_prot_x,
    input  logic               i_prot_r,
    input  logic               i_cacheable,
    input  logic               i_flush,
    input  logic               i_inv_one_valid,
    input  logic [IDX_W-1:0]   i_inv_one_idx,
    input  logic               i_hit_valid,
    input  logic [IDX_W-1:0]   i_hit_idx,
    input  logic               i_dirty_set_valid,
    input  logic [IDX_W-1:0]   i_dirty_set_idx,
    output logic [IDX_W-1:0]   o_refill_idx_c,
    output logic               o_full_c,
    output logic [ENTRIES-1:0] o_valid,
    output logic [ENTRIES-1:0] o_u,
    output logic [ENTRIES-1:0] o_sw,
    output logic [ENTRIES-1:0] o_sx,
    output logic [ENTRIES-1:0] o_sr,
    output logic [ENTRIES-1:0] o_xr,
    output logic [ENTRIES-1:0] o_cash,
    output logic [ENTRIES-1:0] o_dirty
);

    logic [ENTRIES-1:0] r_valid, r_u, r_sw, r_sx, r_sr, r_xr, r_cash, r_dirty;
    logic [ENTRIES-1:1] r_plru;
    logic [ENTRIES-1:1] w_plru_nxt;
    logic [IDX_W-1:0]   w_first_inv;
    logic [IDX_W-1:0]   w_plru_victim;
    logic [IDX_W-1:0]   w_victim;
    logic               w_leaf;

    // Walk from the root following each node's pointer down to a leaf.
    function automatic logic [IDX_W-1:0] plru_victim(input logic [ENTRIES-1:1] plru);
        logic [IDX_W:0] node;
        node = (IDX_W+1)'(1);
        for (int l = 0; l < int'(IDX_W); l++) begin
            node = {node[IDX_W-1:0], plru[node[IDX_W-1:0]]};
        end
        return node[IDX_W-1:0];
    endfunction

    // Point every node on the path to entry e away from the branch taken.
    function automatic logic [ENTRIES-1:1] plru_touch(input logic [ENTRIES-1:1] plru,
                                                       input logic [IDX_W-1:0]   e);
        logic [IDX_W:0]     path;
        logic [IDX_W:0]     node;
        logic [ENTRIES-1:1] res;
        res  = plru;
        path = {1'b1, e};
        for (int l = 0; l < int'(IDX_W); l++) begin
            node = path >> (int'(IDX_W) - l);
            res[node[IDX_W-1:0]] = ~e[int'(IDX_W) - 1 - l];
        end
        return res;
    endfunction

    always_comb begin
        w_first_inv = '0;
        for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_first_inv = IDX_W'(i);
            end
        end
        w_plru_victim = plru_victim(r_plru);
        w_victim      = (&r_valid) ? w_plru_victim : w_first_inv;
    end

    always_comb begin
        w_plru_nxt = r_plru;
        if (i_flush) begin
            w_plru_nxt = '0;
        end else if (i_refill_valid) begin
            w_plru_nxt = plru_touch(r_plru, w_victim);
        end else if (i_hit_valid) begin
            w_plru_nxt = plru_touch(r_plru, i_hit_idx);
        end
    end

    assign w_leaf = i_pte_v & (i_pte_r | (i_pte_x & ~i_pte_w));

    // Later assignments in this block take priority: flush > refill > invalidate/dirty-set.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid <= '0;
            r_u     <= '0;
            r_sw    <= '0;
            r_sx    <= '0;
            r_sr    <= '0;
            r_xr    <= '0;
            r_cash  <= '0;
            r_dirty <= '0;
            r_plru  <= '0;
        end else begin
            r_plru <= w_plru_nxt;
            if (i_inv_one_valid) begin
                r_valid[i_inv_one_idx] <= 1'b0;
            end
            if (i_dirty_set_valid) begin
                r_dirty[i_dirty_set_idx] <= 1'b1;
            end
            if (i_refill_valid) begin
                r_valid[w_victim] <= 1'b1;
                r_u[w_victim]     <= i_pte_u;
                r_sw[w_victim]    <= w_leaf & i_pte_w & i_prot_w;
                r_sx[w_victim]    <= w_leaf & i_pte_x & i_prot_x;
                r_sr[w_victim]    <= w_leaf & i_pte_r & i_prot_r;
                r_xr[w_victim]    <= w_leaf & i_pte_x & i_prot_r;
                r_cash[w_victim]  <= i_cacheable;
                r_dirty[w_victim] <= i_pte_d;
            end
            if (i_flush) begin
                r_valid <= '0;
            end
        end
    end

    assign o_refill_idx_c = w_victim;
    assign o_full_c       = &r_valid;
    assign o_valid        = r_valid;
    assign o_u            = r_u;
    assign o_sw           = r_sw;
    assign o_sx           = r_sx;
    assign o_sr           = r_sr;
    assign o_xr           = r_xr;
    assign o_cash         = r_cash;
    assign o_dirty        = r_dirty;

endmodule

// File: tb/tb_l1_tlb_attr_array.sv
// Bench for l1_tlb_attr_array: directed scenarios followed by random traffic,
// all checked against an array-based reference model of the attribute store.
module tb_l1_tlb_attr_array;

    localparam int unsigned ENTRIES = 8;
    localparam int unsigned IDX_W   = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset, refill_valid;
    logic               pte_v, pte_u, pte_w, pte_x, pte_r, pte_d;
    logic               prot_w, prot_x, prot_r, cacheable;
    logic               flush, inv_one_valid, hit_valid, dirty_set_valid;
    logic [IDX_W-1:0]   inv_one_idx, hit_idx, dirty_set_idx;
    logic [IDX_W-1:0]   refill_idx;
    logic               full;
    logic [ENTRIES-1:0] valid_o, u_o, sw_o, sx_o, sr_o, xr_o, cash_o, dirty_o;

    l1_tlb_attr_array #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) dut (
        .i_clk(clk), .i_reset(reset), .i_refill_valid(refill_valid),
        .i_pte_v(pte_v), .i_pte_u(pte_u), .i_pte_w(pte_w), .i_pte_x(pte_x),
        .i_pte_r(pte_r), .i_pte_d(pte_d), .i_prot_w(prot_w), .i_prot_x(prot_x),
        .i_prot_r(prot_r), .i_cacheable(cacheable), .i_flush(flush),
        .i_inv_one_valid(inv_one_valid), .i_inv_one_idx(inv_one_idx),
        .i_hit_valid(hit_valid), .i_hit_idx(hit_idx),
        .i_dirty_set_valid(dirty_set_valid), .i_dirty_set_idx(dirty_set_idx),
        .o_refill_idx_c(refill_idx), .o_full_c(full),
        .o_valid(valid_o), .o_u(u_o), .o_sw(sw_o), .o_sx(sx_o), .o_sr(sr_o),
        .o_xr(xr_o), .o_cash(cash_o), .o_dirty(dirty_o)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: one bit per entry per attribute, tree bits by heap node number.
    bit m_valid[ENTRIES], m_u[ENTRIES], m_sw[ENTRIES], m_sx[ENTRIES];
    bit m_sr[ENTRIES], m_xr[ENTRIES], m_cash[ENTRIES], m_dirty[ENTRIES];
    int m_tree[ENTRIES];

    function automatic int m_victim();
        int n;
        for (int i = 0; i < int'(ENTRIES); i++) if (!m_valid[i]) return i;
        n = 1;
        while (n < int'(ENTRIES)) n = 2 * n + m_tree[n];
        return n - int'(ENTRIES);
    endfunction

    task automatic m_touch(input int e);
        int n, p;
        n = e + int'(ENTRIES);
        while (n > 1) begin
            p = n / 2;
            m_tree[p] = (n == 2 * p) ? 1 : 0;
            n = p;
        end
    endtask

    task automatic m_clear();
        for (int i = 0; i < int'(ENTRIES); i++) begin
            m_valid[i] = 0; m_u[i] = 0; m_sw[i] = 0; m_sx[i] = 0;
            m_sr[i] = 0; m_xr[i] = 0; m_cash[i] = 0; m_dirty[i] = 0; m_tree[i] = 0;
        end
    endtask

    task automatic m_step();
        int k;
        bit leaf;
        if (reset) begin
            m_clear();
            return;
        end
        k    = m_victim();
        leaf = pte_v && (pte_r || (pte_x && !pte_w));
        if (dirty_set_valid) m_dirty[dirty_set_idx] = 1;
        if (inv_one_valid)   m_valid[inv_one_idx]   = 0;
        if (refill_valid) begin
            m_u[k]     = pte_u;
            m_sw[k]    = leaf && pte_w && prot_w;
            m_sx[k]    = leaf && pte_x && prot_x;
            m_sr[k]    = leaf && pte_r && prot_r;
            m_xr[k]    = leaf && pte_x && prot_r;
            m_cash[k]  = cacheable;
            m_dirty[k] = pte_d;
            m_valid[k] = 1;
        end
        if (flush) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                m_valid[i] = 0;
                m_tree[i]  = 0;
            end
        end else if (refill_valid) begin
            m_touch(k);
        end else if (hit_valid) begin
            m_touch(int'(hit_idx));
        end
    endtask

    function automatic logic [ENTRIES-1:0] pack(input bit a[ENTRIES]);
        logic [ENTRIES-1:0] v;
        for (int i = 0; i < int'(ENTRIES); i++) v[i] = a[i];
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        bit all_v;
        all_v = 1;
        for (int i = 0; i < int'(ENTRIES); i++) all_v &= m_valid[i];
        chk({tag, ".valid"}, 32'(valid_o), 32'(pack(m_valid)));
        chk({tag, ".u"},     32'(u_o),     32'(pack(m_u)));
        chk({tag, ".sw"},    32'(sw_o),    32'(pack(m_sw)));
        chk({tag, ".sx"},    32'(sx_o),    32'(pack(m_sx)));
        chk({tag, ".sr"},    32'(sr_o),    32'(pack(m_sr)));
        chk({tag, ".xr"},    32'(xr_o),    32'(pack(m_xr)));
        chk({tag, ".cash"},  32'(cash_o),  32'(pack(m_cash)));
        chk({tag, ".dirty"}, 32'(dirty_o), 32'(pack(m_dirty)));
        chk({tag, ".ridx"},  32'(refill_idx), 32'(m_victim()));
        chk({tag, ".full"},  32'(full),    32'(all_v));
    endtask

    task automatic idle();
        reset = 0; refill_valid = 0; flush = 0; inv_one_valid = 0;
        hit_valid = 0; dirty_set_valid = 0;
        pte_v = 0; pte_u = 0; pte_w = 0; pte_x = 0; pte_r = 0; pte_d = 0;
        prot_w = 0; prot_x = 0; prot_r = 0; cacheable = 0;
        inv_one_idx = '0; hit_idx = '0; dirty_set_idx = '0;
    endtask

    task automatic cycle(input string tag);
        m_step();
        @(posedge clk);
        #1;
        idle();
        #1;
        chk_model(tag);
    endtask

    task automatic set_pte(input bit v, input bit w, input bit x, input bit r, input bit d);
        refill_valid = 1;
        pte_v = v; pte_w = w; pte_x = x; pte_r = r; pte_d = d;
        pte_u = 1'($urandom); cacheable = 1'($urandom);
        prot_w = 1; prot_x = 1; prot_r = 1;
    endtask

    int k;

    initial begin
        idle();
        m_clear();
        reset = 1;
        cycle("reset");
        chk("reset.ridx", 32'(refill_idx), 32'd0);
        chk("reset.full", 32'(full), 32'd0);

        // Fill all entries with read/write pages.
        for (int i = 0; i < int'(ENTRIES); i++) begin
            chk("t1.ridx_step", 32'(refill_idx), 32'(i));
            set_pte(1, 1, 0, 1, 0);
            cycle("t1");
        end
        chk("t1.valid", 32'(valid_o), 32'hFF);
        chk("t1.sw", 32'(sw_o), 32'hFF);
        chk("t1.sr", 32'(sr_o), 32'hFF);
        chk("t1.sx", 32'(sx_o), 32'h00);
        chk("t1.xr", 32'(xr_o), 32'h00);
        chk("t1.full", 32'(full), 32'd1);

        chk("t2.ridx_pre", 32'(refill_idx), 32'd0);
        hit_valid = 1; hit_idx = 3'd0;
        cycle("t2");
        chk("t2.ridx_post", 32'(refill_idx), 32'd4);

        // Reserved w-without-r encoding is not a leaf.
        set_pte(1, 1, 1, 0, 0);
        cycle("t3");
        chk("t3.valid4", 32'(valid_o[4]), 32'd1);
        chk("t3.sw4", 32'(sw_o[4]), 32'd0);
        chk("t3.sx4", 32'(sx_o[4]), 32'd0);
        chk("t3.sr4", 32'(sr_o[4]), 32'd0);
        chk("t3.xr4", 32'(xr_o[4]), 32'd0);

        k = int'(refill_idx);
        flush = 1;
        set_pte(1, 0, 1, 1, 1);
        cycle("t4");
        chk("t4.valid", 32'(valid_o), 32'h00);
        chk("t4.ridx", 32'(refill_idx), 32'd0);
        chk("t4.sx_k", 32'(sx_o[k]), 32'd1);
        chk("t4.xr_k", 32'(xr_o[k]), 32'd1);
        chk("t4.dirty_k", 32'(dirty_o[k]), 32'd1);

        for (int i = 0; i < int'(ENTRIES); i++) begin
            set_pte(1, 0, 1, 1, 0);
            cycle("t5fill");
        end
        inv_one_valid = 1; inv_one_idx = 3'd5;
        cycle("t5inv");
        chk("t5.valid_inv", 32'(valid_o), 32'hDF);
        chk("t5.ridx", 32'(refill_idx), 32'd5);
        set_pte(1, 1, 0, 1, 0);
        cycle("t5refill");
        chk("t5.valid_full", 32'(valid_o), 32'hFF);

        inv_one_valid = 1; inv_one_idx = 3'd2;
        cycle("t6inv");
        chk("t6.ridx", 32'(refill_idx), 32'd2);
        set_pte(1, 1, 0, 1, 0);
        dirty_set_valid = 1; dirty_set_idx = 3'd2;
        cycle("t6both");
        chk("t6.dirty2", 32'(dirty_o[2]), 32'd0);
        chk("t6.dirty3_pre", 32'(dirty_o[3]), 32'd0);
        dirty_set_valid = 1; dirty_set_idx = 3'd3;
        cycle("t6alone");
        chk("t6.dirty3", 32'(dirty_o[3]), 32'd1);

        // Inverted refill/invalidate collision on the same entry: refill wins.
        inv_one_valid = 1; inv_one_idx = 3'd0;
        cycle("t7inv");
        inv_one_valid = 1; inv_one_idx = 3'd0;
        set_pte(1, 0, 0, 1, 0);
        cycle("t7coll");
        chk("t7.valid0", 32'(valid_o[0]), 32'd1);

        for (int n = 0; n < 400; n++) begin
            reset           = ($urandom_range(99) < 2);
            flush           = ($urandom_range(99) < 5);
            inv_one_valid   = ($urandom_range(99) < 20);
            hit_valid       = ($urandom_range(99) < 50);
            dirty_set_valid = ($urandom_range(99) < 20);
            inv_one_idx     = IDX_W'($urandom);
            hit_idx         = IDX_W'($urandom);
            dirty_set_idx   = IDX_W'($urandom);
            if ($urandom_range(99) < 45) begin
                set_pte(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
                prot_w = 1'($urandom); prot_x = 1'($urandom); prot_r = 1'($urandom);
            end
            cycle("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
